// File: rtl/recon_writer.sv
// recon_writer: reconstructed-frame buffer for the intra-prediction loop.
// Accepts reconstructed 4x4 blocks, writes them one row per cycle into a
// LENGTH x WIDTH byte buffer, and serves top/left neighbour pixels for a
// requested block, substituting 128 for neighbours outside the frame.
module recon_writer #(
  parameter int LENGTH = 256,
  parameter int WIDTH  = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [12:0]  wr_mbnumber,
  input  logic [127:0] wr_pixels,
  output logic         wr_done,
  input  logic         nb_req,
  output logic         nb_ready,
  input  logic [12:0]  nb_mbnumber,
  output logic         nb_valid,
  output logic [63:0]  nb_top,
  output logic [39:0]  nb_left,
  output logic         err
);

  localparam int BPR   = WIDTH / 4;
  localparam int NBLK  = LENGTH * WIDTH / 16;
  localparam int DEPTH = LENGTH * WIDTH;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, FETCH, RESP} state_t;

  state_t        r_state;
  logic [12:0]   r_mb;
  logic [127:0]  r_pix;
  logic [1:0]    r_row;
  logic [63:0]   r_top_s;
  logic [39:0]   r_left_s;
  logic [7:0]    r_mem [DEPTH];

  logic [31:0]   w_brow, w_bcol, w_y, w_x;
  logic [31:0]   w_wbase, w_tbase, w_lbase;
  logic          w_oor, w_we;
  logic [63:0]   w_top;
  logic [39:0]   w_left;

  // Block index decode; one latched index serves both write and fetch.
  assign w_brow  = 32'(r_mb) / 32'(BPR);
  assign w_bcol  = 32'(r_mb) % 32'(BPR);
  assign w_y     = w_brow * 32'd4;
  assign w_x     = w_bcol * 32'd4;
  assign w_oor   = 32'(r_mb) >= 32'(NBLK);
  assign w_wbase = 32'(WIDTH) * (w_y + 32'(r_row)) + w_x;
  // Row above the block; only used when y != 0 so the underflow is masked.
  assign w_tbase = 32'(WIDTH) * (w_y - 32'd1) + w_x;
  // Column left of the block, row 0; only used when x != 0.
  assign w_lbase = 32'(WIDTH) * w_y + w_x - 32'd1;
  assign w_we    = (r_state == WRITE) && !w_oor;

  assign wr_ready = (r_state == IDLE) && !reset;
  assign nb_ready = (r_state == IDLE) && !reset;

  // Buffer write: one 4-byte row per cycle while in WRITE; never reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int c = 0; c < 4; c++)
        r_mem[AW'(w_wbase + 32'(c))] <= r_pix[32*r_row + 8*c +: 8];
    end
  end

  // Neighbour gather with out-of-frame substitution and top-right clamp.
  always_comb begin
    w_top  = '0;
    w_left = '0;
    for (int j = 0; j < 8; j++) begin
      if (w_oor || w_y == 32'd0)
        w_top[8*j +: 8] = 8'd128;
      else if (j > 3 && (w_x + 32'd4) >= 32'(WIDTH))
        w_top[8*j +: 8] = r_mem[AW'(w_tbase + 32'd3)];
      else
        w_top[8*j +: 8] = r_mem[AW'(w_tbase + 32'(j))];
    end
    if (w_oor || w_y == 32'd0 || w_x == 32'd0)
      w_left[7:0] = 8'd128;
    else
      w_left[7:0] = r_mem[AW'(w_tbase - 32'd1)];
    for (int r = 0; r < 4; r++) begin
      if (w_oor || w_x == 32'd0)
        w_left[8*(r+1) +: 8] = 8'd128;
      else
        w_left[8*(r+1) +: 8] = r_mem[AW'(w_lbase + 32'(WIDTH) * 32'(r))];
    end
  end

  // Control FSM with registered pulses and held neighbour outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mb     <= '0;
      r_pix    <= '0;
      r_row    <= '0;
      r_top_s  <= '0;
      r_left_s <= '0;
      wr_done  <= 1'b0;
      nb_valid <= 1'b0;
      err      <= 1'b0;
      nb_top   <= '0;
      nb_left  <= '0;
    end else begin
      wr_done  <= 1'b0;
      nb_valid <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        IDLE: begin
          // Write has priority; a pending nb_req stays pending.
          if (wr_valid) begin
            r_mb    <= wr_mbnumber;
            r_pix   <= wr_pixels;
            r_row   <= 2'd0;
            r_state <= WRITE;
          end else if (nb_req) begin
            r_mb    <= nb_mbnumber;
            r_state <= FETCH;
          end
        end
        WRITE: begin
          r_row <= r_row + 2'd1;
          if (r_row == 2'd3) begin
            wr_done <= 1'b1;
            err     <= w_oor;
            r_state <= IDLE;
          end
        end
        FETCH: begin
          r_top_s  <= w_top;
          r_left_s <= w_left;
          r_state  <= RESP;
        end
        RESP: begin
          nb_top   <= r_top_s;
          nb_left  <= r_left_s;
          nb_valid <= 1'b1;
          err      <= w_oor;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
